// File: rtl/fault_log_pkg.sv
// Shared constants for the fault event logger: flag bit positions and the
// layout of a logged entry {timestamp, flags, change_mask}.
package fault_log_pkg;

  localparam int OV = 0;
  localparam int UV = 1;
  localparam int OC = 2;
  localparam int OT = 3;
  localparam int BF = 4;
  localparam int SD = 5;

  localparam int FLAG_W = 6;

  localparam int MASK_LSB  = 0;
  localparam int FLAGS_LSB = FLAG_W;
  localparam int TS_LSB    = 2 * FLAG_W;

  function automatic int entry_width(input int ts_width);
    return ts_width + 2 * FLAG_W;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is only
// taken when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset, so the head is masked while empty to keep the output at zero.
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_event_logger.sv
// Logs every change of the protection flags as a timestamped entry in a FIFO;
// entries that do not fit are dropped and counted, never back-pressuring.
module fault_event_logger
  import fault_log_pkg::*;
#(
  parameter int TS_WIDTH = 24,
  parameter int PRESCALE = 1000,
  parameter int DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         overvoltage_fault,
  input  logic                         undervoltage_fault,
  input  logic                         overcurrent_fault,
  input  logic                         overtemperature_fault,
  input  logic                         backflow_fault,
  input  logic                         shutdown,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [TS_WIDTH+11:0]         evt_data,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         overflow,
  output logic [7:0]                   drop_count,
  input  logic                         clear_overflow
);

  localparam int ENTRY_W = entry_width(TS_WIDTH);
  localparam int PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [FLAG_W-1:0]   flags;
  logic [FLAG_W-1:0]   prev_flags;
  logic [PS_W-1:0]     prescaler;
  logic [TS_WIDTH-1:0] ts;
  logic                ps_wrap;
  logic                log_event;
  logic                popping;
  logic                fifo_full;
  logic                drop;
  logic [ENTRY_W-1:0]  entry;

  always_comb begin
    flags     = '0;
    flags[OV] = overvoltage_fault;
    flags[UV] = undervoltage_fault;
    flags[OC] = overcurrent_fault;
    flags[OT] = overtemperature_fault;
    flags[BF] = backflow_fault;
    flags[SD] = shutdown;
  end

  assign ps_wrap   = (prescaler == PS_W'(PRESCALE - 1));
  assign log_event = enable && (flags != prev_flags);
  assign popping   = evt_valid && evt_ready;
  assign drop      = log_event && fifo_full && !popping;
  assign entry     = {ts, flags, flags ^ prev_flags};

  // Edge history and the timebase keep running while logging is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_flags <= '0;
      prescaler  <= '0;
      ts         <= '0;
    end else begin
      prev_flags <= flags;
      if (ps_wrap) begin
        prescaler <= '0;
        ts        <= ts + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // A drop in the same cycle as clear_overflow restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_overflow) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (log_event && !drop),
    .push_data (entry),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .valid     (evt_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule
